// File: rtl/layer_sequencer_pkg.sv
// Shared layer-select codes consumed by add_bias and the layer sequencer.
// Holds the cs encodings plus the layer-index to cs mapping.
package layer_sequencer_pkg;

  localparam logic [3:0] IDLE   = 4'h0;
  localparam logic [3:0] LAYER0 = 4'h1;
  localparam logic [3:0] LAYER1 = 4'h2;
  localparam logic [3:0] LAYER2 = 4'h3;
  localparam logic [3:0] LAYER3 = 4'h4;
  localparam logic [3:0] AFFINE = 4'h5;

  localparam logic [2:0] LAST_LYR = 3'd4;

  function automatic logic [3:0] lyr_cs(
    input logic [2:0] l
  );
    logic [3:0] c;
    case (l)
      3'd0:    c = LAYER0;
      3'd1:    c = LAYER1;
      3'd2:    c = LAYER2;
      3'd3:    c = LAYER3;
      default: c = AFFINE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control bundle between the top-level start/done side, the MAC
// engine and the add_bias datapath around layer_sequencer.
interface layer_sequencer_if;

  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] cs;
  logic       eng_start;
  logic       eng_done;
  logic       bias_load;
  logic       res_valid;
  logic       res_ready;

  modport slave (
    input  start,
    input  eng_done,
    input  res_ready,
    output busy,
    output done,
    output error,
    output cs,
    output eng_start,
    output bias_load,
    output res_valid
  );

  modport master (
    output start,
    output eng_done,
    output res_ready,
    input  busy,
    input  done,
    input  error,
    input  cs,
    input  eng_start,
    input  bias_load,
    input  res_valid
  );

endinterface

// File: rtl/layer_sequencer_watchdog.sv
// ENG_RUN timeout counter; only instantiated when
// LAYER_SEQ_WATCHDOG_EN is defined.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);

  localparam logic [TO_W-1:0] LIM =
    TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  assign expire = !clr && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q + TO_W'(1);
    if (clr || expire) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Walks LAYER0..AFFINE through engine run, bias load and result hand-off.
// Define LAYER_SEQ_WATCHDOG_EN to add the ENG_RUN timeout watchdog.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input logic               clk,
  input logic               rst,
  layer_sequencer_if.slave  sif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] P_ENG   = 2'd0;
  localparam logic [1:0] P_BWAIT = 2'd1;
  localparam logic [1:0] P_BLOAD = 2'd2;
  localparam logic [1:0] P_OUT   = 2'd3;

  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_to_w_chk
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  logic [1:0] top_q, top_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] lyr_q, lyr_d;
  logic [3:0] cs_q, cs_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       es_q, es_d;
  logic       bl_q, bl_d;
  logic       rv_q, rv_d;
  logic       in_eng;
  logic       wd_expire;

  assign in_eng = (top_q == S_RUN) && (ph_q == P_ENG);

`ifdef LAYER_SEQ_WATCHDOG_EN
  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_eng),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    top_d   = top_q;
    ph_d    = ph_q;
    lyr_d   = lyr_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    error_d = error_q;
    done_d  = 1'b0;
    es_d    = 1'b0;
    bl_d    = 1'b0;
    rv_d    = 1'b0;
    unique case (1'b1)
      (top_q == S_IDLE): begin
        if (sif.start) begin
          top_d   = S_RUN;
          ph_d    = P_ENG;
          lyr_d   = 3'd0;
          cs_d    = LAYER0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          es_d    = 1'b1;
        end
      end
      (top_q == S_RUN): begin
        unique case (1'b1)
          (ph_q == P_ENG): begin
            if (sif.eng_done) begin
              ph_d = P_BWAIT;
            end else if (wd_expire) begin
              top_d   = S_IDLE;
              cs_d    = IDLE;
              busy_d  = 1'b0;
              error_d = 1'b1;
            end
          end
          (ph_q == P_BWAIT): begin
            ph_d = P_BLOAD;
            bl_d = 1'b1;
          end
          (ph_q == P_BLOAD): begin
            ph_d = P_OUT;
            rv_d = 1'b1;
          end
          default: begin
            rv_d = 1'b1;
            if (sif.res_ready) begin
              rv_d = 1'b0;
              if (lyr_q < LAST_LYR) begin
                lyr_d = lyr_q + 3'd1;
                cs_d  = lyr_cs(lyr_q + 3'd1);
                ph_d  = P_ENG;
                es_d  = 1'b1;
              end else begin
                top_d  = S_FIN;
                busy_d = 1'b0;
                done_d = 1'b1;
              end
            end
          end
        endcase
      end
      (top_q == S_FIN): begin
        top_d = S_IDLE;
        cs_d  = IDLE;
      end
      default: begin
        top_d  = S_IDLE;
        cs_d   = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= S_IDLE;
      ph_q    <= P_ENG;
      lyr_q   <= 3'd0;
      cs_q    <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      es_q    <= 1'b0;
      bl_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      top_q   <= top_d;
      ph_q    <= ph_d;
      lyr_q   <= lyr_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      es_q    <= es_d;
      bl_q    <= bl_d;
      rv_q    <= rv_d;
    end
  end

  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.error     = error_q;
  assign sif.cs        = cs_q;
  assign sif.eng_start = es_q;
  assign sif.bias_load = bl_q;
  assign sif.res_valid = rv_q;

endmodule
